// File: rtl/i2s_tx_unit.sv
// I2S transmitter for the audio clock domain: buffers tick-qualified stereo
// pairs in a 2-entry FIFO and serialises one pair per frame on sck/ws/sdo.
module i2s_tx_unit #(
  parameter int DATA_WIDTH = 24,
  parameter int SCK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_in,
  input  logic                  tick_in,
  input  logic [DATA_WIDTH-1:0] audio0_in,
  input  logic [DATA_WIDTH-1:0] audio1_in,
  output logic                  req_out,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic                  sdo_out,
  output logic                  underrun_out,
  output logic                  overflow_out
);

  localparam int FRAME_W = 2 * DATA_WIDTH;
  localparam int DIV_W   = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam int SLOT_W  = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCK_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(DATA_WIDTH - 1);
  localparam logic [SLOT_W-1:0] WS_LAST   = SLOT_W'(FRAME_W - 2);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, STOPPING} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [FRAME_W-1:0]  fifo0_q, fifo1_q;
  logic [1:0]          fifo_cnt_q;

  logic                at_start, emit, frame_start;
  logic                fifo_wr, fifo_pop, fifo_empty, fifo_full;
  logic [FRAME_W-1:0]  fifo_din, load_word;

  // Counters name the position whose outputs are registered on the next edge,
  // so slot 0 / div 0 is the frame-start edge.
  assign at_start    = (div_q == '0) && (slot_q == '0);
  assign fifo_empty  = (fifo_cnt_q == 2'd0);
  assign fifo_full   = (fifo_cnt_q == 2'd2);
  assign frame_start = (state_q == PLAY) && play_in && at_start;
  assign emit        = ((state_q == PLAY) || (state_q == STOPPING)) && (state_d != IDLE);
  assign fifo_wr     = tick_in && (state_q != IDLE) && (state_d != IDLE);
  assign fifo_pop    = frame_start && !fifo_empty;
  assign fifo_din    = {audio0_in, audio1_in};
  assign load_word   = fifo_empty ? '0 : fifo0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (play_in) state_d = PRIME;
      PRIME:    if (!play_in) state_d = IDLE;
                else if (tick_in) state_d = PLAY;
      PLAY:     if (!play_in) state_d = at_start ? IDLE : STOPPING;
      STOPPING: if (at_start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FIFO: pop decisions use pre-write occupancy; leaving to IDLE flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      fifo_cnt_q <= 2'd0;
    end else if (state_d == IDLE) begin
      fifo_cnt_q <= 2'd0;
    end else begin
      case ({fifo_wr, fifo_pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            fifo0_q    <= fifo_din;
            fifo_cnt_q <= 2'd1;
          end else if (fifo_cnt_q == 2'd1) begin
            fifo1_q    <= fifo_din;
            fifo_cnt_q <= 2'd2;
          end
        end
        2'b01: begin
          fifo0_q    <= fifo1_q;
          fifo_cnt_q <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo0_q <= fifo_din;
          end else begin
            fifo0_q <= fifo1_q;
            fifo1_q <= fifo_din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      slot_q       <= '0;
      shift_q      <= '0;
      req_out      <= 1'b0;
      sck_out      <= 1'b0;
      ws_out       <= 1'b0;
      sdo_out      <= 1'b0;
      underrun_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      req_out      <= ((state_q == IDLE) && play_in) || frame_start;
      underrun_out <= frame_start && fifo_empty;
      overflow_out <= fifo_wr && fifo_full && !fifo_pop;
      if (emit) begin
        if (div_q == DIV_LAST) begin
          div_q  <= '0;
          slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
          div_q <= div_q + 1'b1;
        end
        sck_out <= (div_q >= DIV_HALF);
        ws_out  <= (slot_q >= WS_FIRST) && (slot_q <= WS_LAST);
        if (div_q == '0) begin
          if (frame_start) begin
            sdo_out <= load_word[FRAME_W-1];
            shift_q <= {load_word[FRAME_W-2:0], 1'b0};
          end else begin
            sdo_out <= shift_q[FRAME_W-1];
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
          end
        end
      end else begin
        div_q   <= '0;
        slot_q  <= '0;
        shift_q <= '0;
        sck_out <= 1'b0;
        ws_out  <= 1'b0;
        sdo_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_unit.sv
// Bench for i2s_tx_unit: directed stimulus pushes expected frames; an I2S
// receiver monitor reassembles each frame from sck/ws/sdo and scores it.
module tb_i2s_tx_unit;

  localparam int W = 24;
  localparam logic [47:0] WS_PAT = 48'h0000_01FF_FFFE;

  logic          clk, rst, play_in, tick_in;
  logic [W-1:0]  audio0_in, audio1_in;
  logic          req_out, sck_out, ws_out, sdo_out, underrun_out, overflow_out;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            req_cnt = 0, und_cnt = 0, ovf_cnt = 0;
  logic [47:0]   exp_q[$];

  i2s_tx_unit #(.DATA_WIDTH(W), .SCK_DIV(4)) dut (
    .clk(clk), .rst(rst), .play_in(play_in), .tick_in(tick_in),
    .audio0_in(audio0_in), .audio1_in(audio1_in),
    .req_out(req_out), .sck_out(sck_out), .ws_out(ws_out), .sdo_out(sdo_out),
    .underrun_out(underrun_out), .overflow_out(overflow_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      req_cnt += int'(req_out);
      und_cnt += int'(underrun_out);
      ovf_cnt += int'(overflow_out);
    end
  end

  // Scoreboard monitor: slot 47 is the sck rise where ws falls
  logic        prev_sck = 1'b0, prev_ws = 1'b0;
  logic [47:0] sdo_hist = '0, ws_hist = '0, exp_v;
  int          last_rise = -100;

  always @(negedge clk) begin
    if (rst) begin
      prev_sck  = 1'b0;
      prev_ws   = 1'b0;
      last_rise = -100;
    end else begin
      if (sck_out && !prev_sck) begin
        if (cyc - last_rise <= 8) check("sck_period", 48'(cyc - last_rise), 48'd4);
        last_rise = cyc;
        sdo_hist = {sdo_hist[46:0], sdo_out};
        ws_hist  = {ws_hist[46:0], ws_out};
        if (prev_ws && !ws_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", sdo_hist, 48'hx);
          end else begin
            exp_v = exp_q.pop_front();
            check("frame_data", sdo_hist, exp_v);
            check("ws_pattern", ws_hist, WS_PAT);
          end
        end
        prev_ws = ws_out;
      end
      prev_sck = sck_out;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit push);
    tick_in   = 1'b1;
    audio0_in = l;
    audio1_in = r;
    if (push) exp_q.push_back({l, r});
    step(1);
    tick_in = 1'b0;
  endtask

  function automatic logic [5:0] outs();
    return {req_out, sck_out, ws_out, sdo_out, underrun_out, overflow_out};
  endfunction

  task automatic do_reset();
    rst = 1'b1; play_in = 1'b0; tick_in = 1'b0;
    step(3);
    check("reset_outputs", 48'(outs()), 48'd0);
    rst = 1'b0;
    step(2);
    check("idle_after_reset", 48'(outs()), 48'd0);
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (req_out) begin ok = 1'b1; break; end
      step(1);
    end
    if (!ok) check("req_timeout", 48'd0, 48'd1);
  endtask

  logic [W-1:0] samp_l [5] = '{24'h123456, 24'h000001, 24'h7FFFFF, 24'hA5A5A5, 24'hFEDCBA};
  logic [W-1:0] samp_r [5] = '{24'hABCDEF, 24'hFFFFFF, 24'h800000, 24'h5A5A5A, 24'h013579};
  int req_base, und_base, ovf_base, last_req_cyc;

  initial begin
    rst = 1'b1; play_in = 1'b0; tick_in = 1'b0; audio0_in = '0; audio1_in = '0;

    // Basic frame, then an underrun frame, stop from slot 0
    do_reset();
    req_base = req_cnt; und_base = und_cnt; ovf_base = ovf_cnt;
    play_in = 1'b1;
    step(1);
    check("prime_req", 48'(req_out), 48'd1);
    send(24'h800001, 24'h7FFFFE, 1'b1);
    check("prime_req_one_cycle", 48'(req_out), 48'd0);
    step(1);
    check("start_req", 48'(req_out), 48'd1);
    check("first_bit", 48'(sdo_out), 48'd1);
    exp_q.push_back(48'd0);
    step(192);
    check("underrun_req", 48'(req_out), 48'd1);
    check("underrun_pulse", 48'(underrun_out), 48'd1);
    check("underrun_sdo", 48'(sdo_out), 48'd0);
    play_in = 1'b0;
    step(191);
    check("last_slot_sck_ws", 48'({sck_out, ws_out}), 48'b10);
    step(1);
    check("stop_idle_outputs", 48'(outs()), 48'd0);
    check("req_count_a", 48'(req_cnt - req_base), 48'd3);
    check("underrun_count_a", 48'(und_cnt - und_base), 48'd1);

    // Continuous play, tick 10 cycles after each req, stop at slot 10
    do_reset();
    und_base = und_cnt; ovf_base = ovf_cnt; last_req_cyc = 0;
    play_in = 1'b1;
    step(1);
    for (int k = 0; k < 6; k++) begin
      wait_req();
      if (k >= 2) check("req_period", 48'(cyc - last_req_cyc), 48'd192);
      last_req_cyc = cyc;
      if (k < 5) begin
        step(10);
        send(samp_l[k], samp_r[k], 1'b1);
      end
    end
    check("no_underrun_b", 48'(und_cnt - und_base), 48'd0);
    check("no_overflow_b", 48'(ovf_cnt - ovf_base), 48'd0);
    step(40);
    play_in = 1'b0;
    req_base = req_cnt;
    step(152);
    check("slot10_stop_idle", 48'(outs()), 48'd0);
    check("no_req_after_stop", 48'(req_cnt - req_base), 48'd0);
    play_in = 1'b1;
    step(1);
    check("restart_prime_req", 48'(req_out), 48'd1);
    play_in = 1'b0;
    step(2);

    // Overflow on third tick; full FIFO write+pop keeps order
    do_reset();
    und_base = und_cnt; ovf_base = ovf_cnt;
    play_in = 1'b1;
    step(1);
    send(24'h111111, 24'h222222, 1'b1);
    step(1);
    send(24'h333333, 24'h444444, 1'b1);
    send(24'h555555, 24'h666666, 1'b1);
    send(24'h777777, 24'h888888, 1'b0);
    check("overflow_pulse", 48'(overflow_out), 48'd1);
    step(1);
    check("overflow_one_cycle", 48'(overflow_out), 48'd0);
    step(187);
    send(24'h999999, 24'hAAAAAA, 1'b1);
    check("full_write_pop_no_ovf", 48'(overflow_out), 48'd0);
    check("full_write_pop_req", 48'(req_out), 48'd1);
    step(192);
    step(192);
    play_in = 1'b0;
    step(192);
    check("ovf_test_idle", 48'(outs()), 48'd0);
    check("overflow_count", 48'(ovf_cnt - ovf_base), 48'd1);
    check("underrun_count_c", 48'(und_cnt - und_base), 48'd0);

    // Asynchronous reset mid-frame flushes the FIFO
    do_reset();
    play_in = 1'b1;
    step(1);
    send(24'hC0FFEE, 24'hBADBAD, 1'b0);
    step(1);
    send(24'hDEAD01, 24'hBEEF02, 1'b0);
    step(120);
    check("slot30_ws_sck", 48'({ws_out, sck_out}), 48'b10);
    #2;
    rst = 1'b1;
    play_in = 1'b0;
    #1;
    check("async_rst_outputs", 48'({sck_out, ws_out, sdo_out, req_out}), 48'd0);
    step(5);
    rst = 1'b0;
    play_in = 1'b1;
    und_base = und_cnt;
    step(1);
    check("post_rst_prime_req", 48'(req_out), 48'd1);
    send(24'h0F0F0F, 24'hF0F0F0, 1'b1);
    exp_q.push_back(48'd0);
    step(1);
    step(192);
    check("flushed_fifo_underrun", 48'(underrun_out), 48'd1);
    play_in = 1'b0;
    step(192);
    check("rst_test_idle", 48'(outs()), 48'd0);
    check("underrun_count_d", 48'(und_cnt - und_base), 48'd1);

    step(4);
    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
